clock_display_core: RTL and testbench



---
 rtl/clock_display_pkg.sv | 43 ++++
 rtl/clock_display_if.sv | 19 +
 rtl/seg7_glyph.sv | 27 ++
 rtl/clock_display_core.sv | 259 +++++++++++++++++++++++++
 tb/tb_clock_display_core.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_display_pkg.sv
// Shared types, glyphs and BCD helpers for the clock display core.
// Glyph bit order is {g,f,e,d,c,b,a}, active-high.
package clock_display_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_CHECK = 2'd2
  } set_state_e;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Valid for 0..59 only; callers never pass more.
  function automatic logic [7:0] bin_to_bcd8(input logic [5:0] bin);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(bin / 6'd10);
    units = 4'(bin % 6'd10);
    return {tens, units};
  endfunction

  function automatic logic [4:0] hour24_to_12(input logic [4:0] h24);
    if (h24 == 5'd0)
      return 5'd12;
    else if (h24 > 5'd12)
      return h24 - 5'd12;
    else
      return h24;
  endfunction

endpackage

// File: rtl/clock_display_if.sv
// Time-set handshake between the button/UART front-end (master) and the core (slave).
interface clock_display_if;
  logic       set_valid;
  logic       set_ready;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic [5:0] set_ss;
  logic       set_err;

  modport master (
    output set_valid, set_hh, set_mm, set_ss,
    input  set_ready, set_err
  );

  modport slave (
    input  set_valid, set_hh, set_mm, set_ss,
    output set_ready, set_err
  );
endinterface

// File: rtl/seg7_glyph.sv
// BCD digit to active-high 7-segment pattern, with a blanking override.
module seg7_glyph
  import clock_display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             blank,
  output logic [6:0]       pattern
);
  always_comb begin
    pattern = GLYPH_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    pattern = GLYPH_0;
        4'd1:    pattern = GLYPH_1;
        4'd2:    pattern = GLYPH_2;
        4'd3:    pattern = GLYPH_3;
        4'd4:    pattern = GLYPH_4;
        4'd5:    pattern = GLYPH_5;
        4'd6:    pattern = GLYPH_6;
        4'd7:    pattern = GLYPH_7;
        4'd8:    pattern = GLYPH_8;
        4'd9:    pattern = GLYPH_9;
        default: pattern = GLYPH_BLANK;
      endcase
    end
  end
endmodule

// File: rtl/clock_display_core.sv
// BCD HH:MM:SS timekeeper with set handshake, 12/24 h display and 4/6-digit scanner.
// Optional alarm logic and ports are built when ALARM_EN is defined.
//
// state   | meaning
// S_INIT  | first cycle after reset, set_ready low
// S_IDLE  | set_ready high, waiting for set_valid
// S_CHECK | captured set being range-checked; load or set_err this cycle
module clock_display_core
  import clock_display_pkg::*;
#(
  parameter int CLK_HZ         = 27000000,
  parameter int MUX_HZ         = 1000,
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0,
  parameter int RESET_HH       = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  run_en,
  input  logic                  mode_12h,
  clock_display_if.slave        set_bus,
  output logic                  tick_1hz,
  output logic [7:0]            hh_bcd,
  output logic [7:0]            mm_bcd,
  output logic [7:0]            ss_bcd,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] dig_sel
`ifdef ALARM_EN
  ,
  input  logic [4:0]            alarm_hh,
  input  logic [5:0]            alarm_mm,
  input  logic                  alarm_arm,
  input  logic                  alarm_ack,
  output logic                  alarm
`endif
);

  localparam int SCAN_PERIOD = CLK_HZ / MUX_HZ;
  localparam int PW          = $clog2(CLK_HZ + 1);
  localparam int SCW         = $clog2(SCAN_PERIOD + 1);

  if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_digits
    $error("clock_display_core: NUM_DIGITS must be 4 or 6");
  end
  if (SCAN_PERIOD < 1) begin : g_bad_mux
    $error("clock_display_core: CLK_HZ/MUX_HZ must be at least 1");
  end

  set_state_e    state_q, state_d;
  logic          accept, load_now, in_range, set_ready_c, set_err_c;
  logic [4:0]    cap_hh;
  logic [5:0]    cap_mm, cap_ss;
  logic [PW-1:0] presc;
  logic          presc_tc, half_sec, alarm_on;
  logic [7:0]    hh_inc, mm_inc, ss_inc;

  assign in_range = (cap_hh <= 5'd23) && (cap_mm <= 6'd59) && (cap_ss <= 6'd59);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= S_INIT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    load_now    = 1'b0;
    set_ready_c = 1'b0;
    set_err_c   = 1'b0;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        set_ready_c = 1'b1;
        if (set_bus.set_valid) begin
          accept  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        load_now  = in_range;
        set_err_c = !in_range;
        state_d   = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign set_bus.set_ready = set_ready_c;
  assign set_bus.set_err   = set_err_c;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cap_hh <= '0;
      cap_mm <= '0;
      cap_ss <= '0;
    end else if (accept) begin
      cap_hh <= set_bus.set_hh;
      cap_mm <= set_bus.set_mm;
      cap_ss <= set_bus.set_ss;
    end
  end

  assign presc_tc = (presc == PW'(CLK_HZ - 1));
  assign half_sec = (presc < PW'(CLK_HZ / 2));
  // A load in S_CHECK swallows a coincident tick.
  assign tick_1hz = run_en && presc_tc && !load_now;

  always_comb begin
    ss_inc = ss_bcd;
    mm_inc = mm_bcd;
    hh_inc = hh_bcd;
    if (ss_bcd[3:0] != 4'd9)
      ss_inc[3:0] = ss_bcd[3:0] + 4'd1;
    else if (ss_bcd[7:4] != 4'd5)
      ss_inc = {ss_bcd[7:4] + 4'd1, 4'd0};
    else begin
      ss_inc = 8'h00;
      if (mm_bcd[3:0] != 4'd9)
        mm_inc[3:0] = mm_bcd[3:0] + 4'd1;
      else if (mm_bcd[7:4] != 4'd5)
        mm_inc = {mm_bcd[7:4] + 4'd1, 4'd0};
      else begin
        mm_inc = 8'h00;
        if (hh_bcd == 8'h23)
          hh_inc = 8'h00;
        else if (hh_bcd[3:0] != 4'd9)
          hh_inc[3:0] = hh_bcd[3:0] + 4'd1;
        else
          hh_inc = {hh_bcd[7:4] + 4'd1, 4'd0};
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      presc  <= '0;
      hh_bcd <= bin_to_bcd8(6'(RESET_HH));
      mm_bcd <= 8'h00;
      ss_bcd <= 8'h00;
    end else if (load_now) begin
      presc  <= '0;
      hh_bcd <= bin_to_bcd8({1'b0, cap_hh});
      mm_bcd <= bin_to_bcd8(cap_mm);
      ss_bcd <= bin_to_bcd8(cap_ss);
    end else if (run_en) begin
      if (presc_tc) begin
        presc  <= '0;
        hh_bcd <= hh_inc;
        mm_bcd <= mm_inc;
        ss_bcd <= ss_inc;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

`ifdef ALARM_EN
  logic [5:0] alarm_cnt;
  logic       alarm_hit;

  assign alarm_hit = tick_1hz && alarm_arm && (ss_inc == 8'h00) &&
                     (hh_inc == bin_to_bcd8({1'b0, alarm_hh})) &&
                     (mm_inc == bin_to_bcd8(alarm_mm));

  // Down-counts the ticks left before the alarm self-clears.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else if (alarm_ack || !alarm_arm) begin
      alarm <= 1'b0;
    end else if (alarm_hit) begin
      alarm     <= 1'b1;
      alarm_cnt <= 6'd59;
    end else if (alarm && tick_1hz) begin
      if (alarm_cnt == 6'd0) alarm <= 1'b0;
      else                   alarm_cnt <= alarm_cnt - 6'd1;
    end
  end
  assign alarm_on = alarm;
`else
  assign alarm_on = 1'b0;
`endif

  logic [SCW-1:0]        scan_cnt;
  logic [2:0]            scan_idx;
  logic [4:0]            hh_bin, hh_12;
  logic [7:0]            disp_hh;
  logic [3:0]            dig_val [6];
  logic [3:0]            cur_digit;
  logic                  cur_blank, dp_next;
  logic [6:0]            cur_pattern;
  logic [NUM_DIGITS-1:0] sel_next;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scan_cnt <= SCW'(SCAN_PERIOD - 1);
      scan_idx <= '0;
    end else if (scan_cnt == '0) begin
      scan_cnt <= SCW'(SCAN_PERIOD - 1);
      scan_idx <= (scan_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt - SCW'(1);
    end
  end

  assign hh_bin  = 5'(hh_bcd[7:4]) * 5'd10 + 5'(hh_bcd[3:0]);
  assign hh_12   = hour24_to_12(hh_bin);
  assign disp_hh = mode_12h ? bin_to_bcd8({1'b0, hh_12}) : hh_bcd;

  always_comb begin
    if (NUM_DIGITS == 6) begin
      dig_val[0] = ss_bcd[3:0];
      dig_val[1] = ss_bcd[7:4];
      dig_val[2] = mm_bcd[3:0];
      dig_val[3] = mm_bcd[7:4];
      dig_val[4] = disp_hh[3:0];
      dig_val[5] = disp_hh[7:4];
    end else begin
      dig_val[0] = mm_bcd[3:0];
      dig_val[1] = mm_bcd[7:4];
      dig_val[2] = disp_hh[3:0];
      dig_val[3] = disp_hh[7:4];
      dig_val[4] = 4'd0;
      dig_val[5] = 4'd0;
    end
  end

  always_comb begin
    cur_digit = dig_val[scan_idx];
    cur_blank = mode_12h && (scan_idx == 3'(NUM_DIGITS - 1)) && (disp_hh[7:4] == 4'd0);
    sel_next  = NUM_DIGITS'(1) << scan_idx;
    if (alarm_on)
      dp_next = half_sec;
    else
      dp_next = (scan_idx == 3'(NUM_DIGITS - 2)) && (half_sec || !run_en);
  end

  seg7_glyph u_glyph (
    .bcd     (cur_digit),
    .blank   (cur_blank),
    .pattern (cur_pattern)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      seg     <= (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
      dp      <= (SEG_ACTIVE_LOW != 0);
      dig_sel <= (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    end else begin
      seg     <= (SEG_ACTIVE_LOW != 0) ? ~cur_pattern : cur_pattern;
      dp      <= (SEG_ACTIVE_LOW != 0) ? ~dp_next : dp_next;
      dig_sel <= (SEL_ACTIVE_LOW != 0) ? ~sel_next : sel_next;
    end
  end

endmodule

// File: tb/tb_clock_display_core.sv
// Self-checking bench for clock_display_core against a seconds-of-day reference model.
module tb_clock_display_core;
  localparam int CLK_HZ = 10;
  localparam int MUX_HZ = 5;
  localparam int ND     = 6;
  localparam int RHH    = 22;
  localparam int PER    = CLK_HZ / MUX_HZ;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          run_en = 1'b0;
  logic          mode_12h = 1'b0;
  logic          tick_1hz;
  logic [7:0]    hh_bcd, mm_bcd, ss_bcd;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] dig_sel;
`ifdef ALARM_EN
  logic [4:0]    alarm_hh = 5'd0;
  logic [5:0]    alarm_mm = 6'd0;
  logic          alarm_arm = 1'b0;
  logic          alarm_ack = 1'b0;
  logic          alarm;
`endif

  clock_display_if set_bus();

  clock_display_core #(
    .CLK_HZ(CLK_HZ), .MUX_HZ(MUX_HZ), .NUM_DIGITS(ND),
    .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0), .RESET_HH(RHH)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .run_en   (run_en),
    .mode_12h (mode_12h),
    .set_bus  (set_bus),
    .tick_1hz (tick_1hz),
    .hh_bcd   (hh_bcd),
    .mm_bcd   (mm_bcd),
    .ss_bcd   (ss_bcd),
    .seg      (seg),
    .dp       (dp),
    .dig_sel  (dig_sel)
`ifdef ALARM_EN
    ,
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .alarm_arm (alarm_arm),
    .alarm_ack (alarm_ack),
    .alarm     (alarm)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [6:0] GL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int total = 0;
  int bad   = 0;
  int m_sec, m_pre, m_edges, ld_val;
  bit ld_now;
  int p_sec, p_pre, p_idx;
  bit p_run, p_mode;

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic logic [23:0] exp_time();
    return {bcd(m_sec / 3600), bcd((m_sec / 60) % 60), bcd(m_sec % 60)};
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input int sec, input bit m12);
    int h, m, s, hd, d;
    bit blank;
    h  = sec / 3600;
    m  = (sec / 60) % 60;
    s  = sec % 60;
    hd = m12 ? ((h == 0) ? 12 : ((h > 12) ? h - 12 : h)) : h;
    blank = 1'b0;
    case (idx)
      0: d = s % 10;
      1: d = s / 10;
      2: d = m % 10;
      3: d = m / 10;
      4: d = hd % 10;
      default: begin
        d = hd / 10;
        blank = m12 && (d == 0);
      end
    endcase
    return blank ? 7'h00 : GL[d];
  endfunction

  task automatic model_reset();
    m_sec   = RHH * 3600;
    m_pre   = 0;
    m_edges = 0;
    ld_now  = 1'b0;
  endtask

  task automatic clk_step();
    p_sec  = m_sec;
    p_pre  = m_pre;
    p_run  = run_en;
    p_mode = mode_12h;
    p_idx  = (m_edges / PER) % ND;
    @(posedge sys_clk);
    m_edges++;
    if (ld_now) begin
      m_sec  = ld_val;
      m_pre  = 0;
      ld_now = 1'b0;
    end else if (p_run) begin
      if (m_pre == CLK_HZ - 1) begin
        m_pre = 0;
        m_sec = (m_sec + 1) % 86400;
      end else begin
        m_pre++;
      end
    end
    #1;
  endtask

  task automatic do_set(input int hh, input int mm, input int ss, input string tag);
    bit ok;
    int n;
    ok = (hh <= 23) && (mm <= 59) && (ss <= 59);
    n = 0;
    while (set_bus.set_ready !== 1'b1 && n < 10) begin
      clk_step();
      n++;
    end
    total++;
    if (set_bus.set_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_wait: set_ready=%b required 1 within 10 cycles", tag, set_bus.set_ready);
    end
    set_bus.set_valid = 1'b1;
    set_bus.set_hh    = 5'(hh);
    set_bus.set_mm    = 6'(mm);
    set_bus.set_ss    = 6'(ss);
    clk_step();
    set_bus.set_valid = 1'b0;
    total++;
    if (set_bus.set_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_ready_drop: set_ready=%b required 0", tag, set_bus.set_ready);
    end
    total++;
    if (set_bus.set_err !== !ok) begin
      bad++;
      $display("FAIL %s_err: set_err=%b required %b (%0d:%0d:%0d)", tag, set_bus.set_err, !ok, hh, mm, ss);
    end
    total++;
    if (tick_1hz !== (!ok && run_en && m_pre == CLK_HZ - 1)) begin
      bad++;
      $display("FAIL %s_tick: tick_1hz=%b required %b", tag, tick_1hz, (!ok && run_en && m_pre == CLK_HZ - 1));
    end
    if (ok) begin
      ld_now = 1'b1;
      ld_val = hh * 3600 + mm * 60 + ss;
    end
    clk_step();
    total++;
    if (set_bus.set_ready !== 1'b1 || set_bus.set_err !== 1'b0) begin
      bad++;
      $display("FAIL %s_return: ready=%b err=%b required ready=1 err=0", tag, set_bus.set_ready, set_bus.set_err);
    end
    total++;
    if ({hh_bcd, mm_bcd, ss_bcd} !== exp_time()) begin
      bad++;
      $display("FAIL %s_time: got %h:%h:%h required %h", tag, hh_bcd, mm_bcd, ss_bcd, exp_time());
    end
  endtask

  task automatic test_reset();
    run_en = 1'b1;
    set_bus.set_valid = 1'b0;
    set_bus.set_hh = '0;
    set_bus.set_mm = '0;
    set_bus.set_ss = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    total++;
    if ({tick_1hz, set_bus.set_ready, set_bus.set_err, dp} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: tick/ready/err/dp=%b%b%b%b required 0000", tick_1hz, set_bus.set_ready, set_bus.set_err, dp);
    end
    total++;
    if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h220000) begin
      bad++;
      $display("FAIL reset_time: got %h:%h:%h required 22:00:00", hh_bcd, mm_bcd, ss_bcd);
    end
    total++;
    if (seg !== 7'h00 || dig_sel !== 6'b000000) begin
      bad++;
      $display("FAIL reset_display: seg=%h dig_sel=%b required seg=00 dig_sel=000000", seg, dig_sel);
    end
    sys_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_run_scan();
    int ticks;
    logic [ND-1:0] exp_sel;
    ticks = 0;
    for (int e = 1; e <= 12; e++) begin
      if (e <= 10 && tick_1hz === 1'b1) ticks++;
      clk_step();
      exp_sel = ND'(1) << (((e - 1) / PER) % ND);
      total++;
      if (dig_sel !== exp_sel) begin
        bad++;
        $display("FAIL scan_dig_sel: edge %0d dig_sel=%b required %b", e, dig_sel, exp_sel);
      end
      if (e == 1) begin
        total++;
        if (set_bus.set_ready !== 1'b1) begin
          bad++;
          $display("FAIL init_ready: set_ready=%b required 1 one cycle after reset", set_bus.set_ready);
        end
      end
      if (e == 10) begin
        total++;
        if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h220001) begin
          bad++;
          $display("FAIL first_second: got %h:%h:%h required 22:00:01", hh_bcd, mm_bcd, ss_bcd);
        end
      end
    end
    total++;
    if (ticks != 1) begin
      bad++;
      $display("FAIL tick_count: %0d ticks in 10 cycles, required 1", ticks);
    end
  endtask

  task automatic test_wrap();
    run_en = 1'b1;
    do_set(23, 59, 59, "wrap_set");
    for (int i = 0; i < CLK_HZ; i++) begin
      clk_step();
      total++;
      if (hh_bcd === 8'h24 || {hh_bcd, mm_bcd, ss_bcd} !== exp_time()) begin
        bad++;
        $display("FAIL wrap_track: cycle %0d got %h:%h:%h required %h", i, hh_bcd, mm_bcd, ss_bcd, exp_time());
      end
    end
    total++;
    if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h000000) begin
      bad++;
      $display("FAIL wrap_midnight: got %h:%h:%h required 00:00:00", hh_bcd, mm_bcd, ss_bcd);
    end
  endtask

  task automatic test_set_err();
    run_en = 1'b1;
    do_set(24, 10, 10, "err_hh24");
    do_set(5, 60, 0, "err_mm60");
    do_set(5, 0, 60, "err_ss60");
    do_set(23, 59, 59, "edge_max");
  endtask

  task automatic test_set_at_tc();
    int n;
    run_en = 1'b1;
    n = 0;
    while (m_pre != CLK_HZ - 2 && n < 2 * CLK_HZ) begin
      clk_step();
      n++;
    end
    total++;
    if (m_pre != CLK_HZ - 2) begin
      bad++;
      $display("FAIL tc_align: prescaler model %0d required %0d", m_pre, CLK_HZ - 2);
    end
    do_set(12, 34, 56, "tc_set");
    total++;
    if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h123456) begin
      bad++;
      $display("FAIL tc_exact: got %h:%h:%h required 12:34:56", hh_bcd, mm_bcd, ss_bcd);
    end
    repeat (CLK_HZ) clk_step();
    total++;
    if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h123457) begin
      bad++;
      $display("FAIL tc_next_second: got %h:%h:%h required 12:34:57", hh_bcd, mm_bcd, ss_bcd);
    end
  endtask

  task automatic check_hours(input logic [6:0] exp_hh1, input logic [6:0] exp_hh0, input string tag);
    int hits;
    hits = 0;
    for (int i = 0; i < 2 * PER * ND; i++) begin
      clk_step();
      if (dig_sel === 6'b100000) begin
        hits++;
        total++;
        if (seg !== exp_hh1) begin
          bad++;
          $display("FAIL %s_hh1: seg=%h required %h", tag, seg, exp_hh1);
        end
      end
      if (dig_sel === 6'b010000) begin
        hits++;
        total++;
        if (seg !== exp_hh0 || dp !== 1'b1) begin
          bad++;
          $display("FAIL %s_hh0: seg=%h dp=%b required seg=%h dp=1", tag, seg, dp, exp_hh0);
        end
      end
    end
    total++;
    if (hits < 4) begin
      bad++;
      $display("FAIL %s_hits: hour digits selected %0d times, required at least 4", tag, hits);
    end
  endtask

  task automatic test_12h();
    run_en = 1'b0;
    mode_12h = 1'b1;
    do_set(0, 5, 0, "h12_set0");
    check_hours(7'h06, 7'h5B, "h12_midnight");
    do_set(9, 5, 0, "h12_set9");
    check_hours(7'h00, 7'h6F, "h12_blank");
    do_set(15, 5, 0, "h12_set15");
    check_hours(7'h00, 7'h4F, "h12_pm");
    mode_12h = 1'b0;
    do_set(9, 5, 0, "h24_set9");
    check_hours(7'h3F, 7'h6F, "h24_noblank");
    run_en = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      total++;
      if (tick_1hz !== (run_en && m_pre == CLK_HZ - 1)) begin
        bad++;
        $display("FAIL rand_tick: cycle %0d tick_1hz=%b required %b", i, tick_1hz, (run_en && m_pre == CLK_HZ - 1));
      end
      total++;
      if ({hh_bcd, mm_bcd, ss_bcd} !== exp_time()) begin
        bad++;
        $display("FAIL rand_time: cycle %0d got %h:%h:%h required %h", i, hh_bcd, mm_bcd, ss_bcd, exp_time());
      end
      total++;
      if (seg !== exp_seg(p_idx, p_sec, p_mode) || dig_sel !== (ND'(1) << p_idx)) begin
        bad++;
        $display("FAIL rand_display: cycle %0d seg=%h sel=%b required seg=%h sel=%b", i, seg, dig_sel,
                 exp_seg(p_idx, p_sec, p_mode), ND'(1) << p_idx);
      end
      total++;
      if (dp !== (p_idx == 4 && (p_pre < CLK_HZ / 2 || !p_run))) begin
        bad++;
        $display("FAIL rand_dp: cycle %0d dp=%b required %b", i, dp, (p_idx == 4 && (p_pre < CLK_HZ / 2 || !p_run)));
      end
      if ($urandom_range(0, 19) == 0) run_en = !run_en;
      if ($urandom_range(0, 29) == 0) mode_12h = !mode_12h;
      if ($urandom_range(0, 24) == 0)
        do_set(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), "rand_set");
      clk_step();
    end
  endtask

  task automatic test_reset_mid_set();
    run_en = 1'b1;
    set_bus.set_valid = 1'b1;
    set_bus.set_hh = 5'd10;
    set_bus.set_mm = 6'd10;
    set_bus.set_ss = 6'd10;
    clk_step();
    set_bus.set_valid = 1'b0;
    sys_rst = 1'b1;
    #1;
    total++;
    if (set_bus.set_ready !== 1'b0 || {hh_bcd, mm_bcd, ss_bcd} !== 24'h220000 || dig_sel !== 6'b000000) begin
      bad++;
      $display("FAIL midset_reset: ready=%b time=%h:%h:%h sel=%b required 0, 22:00:00, 000000",
               set_bus.set_ready, hh_bcd, mm_bcd, ss_bcd, dig_sel);
    end
    sys_rst = 1'b0;
    model_reset();
    clk_step();
    clk_step();
    total++;
    if ({hh_bcd, mm_bcd, ss_bcd} !== exp_time() || set_bus.set_ready !== 1'b1 || set_bus.set_err !== 1'b0) begin
      bad++;
      $display("FAIL midset_lost: time=%h:%h:%h ready=%b err=%b required %h ready=1 err=0",
               hh_bcd, mm_bcd, ss_bcd, set_bus.set_ready, set_bus.set_err, exp_time());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_scan();
    test_wrap();
    test_set_err();
    test_set_at_tc();
    test_12h();
    test_random();
    test_reset_mid_set();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
